// File: rtl/mem_arbiter.sv
// Byte-serial sequencer for the shared RAM/IO port: round-robin arbitration between
// instruction fetch and the LSU, with little-endian assembly of multi-byte reads.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transfer in flight; arbitration happens here
// ST_READ  | issuing byte addresses; captures lag the issue by two edges
// ST_WRITE | one byte per cycle on the bus, stalled by a full IO buffer
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        lsu_en,
  input  logic        lsu_wr,
  input  logic [2:0]  lsu_size,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  input  logic        misbranch_flag,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        last_lsu_q, last_lsu_d;
  logic        slot_vld_q, slot_vld_d;
  logic        slot_wr_q, slot_wr_d;
  logic [2:0]  slot_size_q, slot_size_d;
  logic [31:0] slot_addr_q, slot_addr_d;
  logic [31:0] slot_wdata_q, slot_wdata_d;
  logic        cur_lsu_q, cur_lsu_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        if_done_q, if_done_d;
  logic        lsu_done_q, lsu_done_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;

  logic        live_ok, slot_ok, lsu_req, req_wr, gnt_lsu, io_stall;
  logic [2:0]  req_size, k_nxt, cap_idx;
  logic [31:0] req_addr, req_wdata, rbuf_cap;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
  endfunction

  // A flush discards reads (queued or arriving this edge); writes always survive.
  assign live_ok   = lsu_en & ~(misbranch_flag & ~lsu_wr);
  assign slot_ok   = slot_vld_q & ~(misbranch_flag & ~slot_wr_q);
  assign lsu_req   = slot_ok | live_ok;
  assign req_wr    = slot_ok ? slot_wr_q    : lsu_wr;
  assign req_size  = slot_ok ? slot_size_q  : lsu_size;
  assign req_addr  = slot_ok ? slot_addr_q  : lsu_addr;
  assign req_wdata = slot_ok ? slot_wdata_q : lsu_wdata;
  assign gnt_lsu   = lsu_req & (~if_en | ~last_lsu_q);
  assign io_stall  = io_buffer_full & (addr_q[17:16] == 2'b11);
  assign k_nxt     = k_q + 3'd1;
  assign cap_idx   = k_q - 3'd1;

  always_comb begin
    rbuf_cap = rbuf_q;
    for (int b = 0; b < 4; b++) begin
      if (cap_idx == 3'(b)) rbuf_cap[8*b +: 8] = mem_din;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_lsu_d   = last_lsu_q;
    slot_vld_d   = slot_vld_q;
    slot_wr_d    = slot_wr_q;
    slot_size_d  = slot_size_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    cur_lsu_d    = cur_lsu_q;
    addr_d       = addr_q;
    n_d          = n_q;
    k_d          = k_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    if_done_d    = if_done_q;
    lsu_done_d   = lsu_done_q;
    if_rdata_d   = if_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;

    if (rdy) begin
      if_done_d  = 1'b0;
      lsu_done_d = 1'b0;
      if (slot_vld_q && !slot_ok) slot_vld_d = 1'b0;
      if (live_ok) begin
        slot_vld_d   = 1'b1;
        slot_wr_d    = lsu_wr;
        slot_size_d  = lsu_size;
        slot_addr_d  = lsu_addr;
        slot_wdata_d = lsu_wdata;
      end

      case (state_q)
        ST_IDLE: begin
          if (if_en || lsu_req) begin
            last_lsu_d = gnt_lsu;
            cur_lsu_d  = gnt_lsu;
            k_d        = 3'd0;
            rbuf_d     = '0;
            if (gnt_lsu) begin
              slot_vld_d = 1'b0;
              addr_d     = req_addr;
              n_d        = req_size;
              wdata_d    = req_wdata;
              mem_a_d    = req_addr;
              if (req_wr) begin
                mem_dout_d = req_wdata[7:0];
                state_d    = ST_WRITE;
              end else begin
                state_d    = ST_READ;
              end
            end else begin
              addr_d  = if_addr;
              n_d     = 3'd4;
              mem_a_d = if_addr;
              state_d = ST_READ;
            end
          end
        end
        ST_READ: begin
          if (misbranch_flag) begin
            state_d = ST_IDLE;
          end else begin
            rbuf_d = rbuf_cap;
            if (k_q == n_q) begin
              state_d = ST_IDLE;
              if (cur_lsu_q) begin
                lsu_done_d  = 1'b1;
                lsu_rdata_d = rbuf_cap;
              end else begin
                if_done_d  = 1'b1;
                if_rdata_d = rbuf_cap;
              end
            end else begin
              k_d = k_nxt;
              if (k_nxt < n_q) mem_a_d = addr_q + {29'd0, k_nxt};
            end
          end
        end
        ST_WRITE: begin
          if (!io_stall) begin
            if (k_nxt == n_q) begin
              state_d    = ST_IDLE;
              lsu_done_d = 1'b1;
            end else begin
              k_d        = k_nxt;
              mem_a_d    = addr_q + {29'd0, k_nxt};
              mem_dout_d = byte_sel(wdata_q, k_nxt[1:0]);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_lsu_q   <= 1'b0;
      slot_vld_q   <= 1'b0;
      slot_wr_q    <= 1'b0;
      slot_size_q  <= '0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      cur_lsu_q    <= 1'b0;
      addr_q       <= '0;
      n_q          <= '0;
      k_q          <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      if_done_q    <= 1'b0;
      lsu_done_q   <= 1'b0;
      if_rdata_q   <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_lsu_q   <= last_lsu_d;
      slot_vld_q   <= slot_vld_d;
      slot_wr_q    <= slot_wr_d;
      slot_size_q  <= slot_size_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      cur_lsu_q    <= cur_lsu_d;
      addr_q       <= addr_d;
      n_q          <= n_d;
      k_q          <= k_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      if_done_q    <= if_done_d;
      lsu_done_q   <= lsu_done_d;
      if_rdata_q   <= if_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign lsu_done  = lsu_done_q;
  assign lsu_rdata = lsu_rdata_q;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = (state_q == ST_WRITE) & rdy & ~io_stall;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch after reset, LSU reads/writes, IO stall,
// round-robin alternation, branch flush and rdy freeze.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        if_en;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        lsu_en;
  logic        lsu_wr;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        misbranch_flag;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]  ram [logic [31:0]];
  logic [31:0] wlog_a [$];
  logic [7:0]  wlog_d [$];

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .lsu_en(lsu_en), .lsu_wr(lsu_wr), .lsu_size(lsu_size), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .misbranch_flag(misbranch_flag), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model shares the rdy clock enable so in-flight read data survives a freeze.
  always @(posedge clk) begin
    if (rdy) mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    if (mem_wr) begin
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_lsu(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
    lsu_en = 1'b1; lsu_wr = wr; lsu_size = sz; lsu_addr = a; lsu_wdata = wd;
    tick();
    lsu_en = 1'b0;
  endtask

  task automatic wait_lsu_done(output int lat);
    lat = 0;
    while (lsu_done !== 1'b1 && lat < 30) begin tick(); lat++; end
  endtask

  task automatic wait_if_done(output int lat);
    lat = 0;
    while (if_done !== 1'b1 && lat < 30) begin tick(); lat++; end
  endtask

  int lat, cnt;
  bit exp_lsu, prev_lsu;
  logic [31:0] sw_word;

  initial begin
    rst = 1'b0; rdy = 1'b1; if_en = 1'b1; if_addr = 32'h0;
    lsu_en = 1'b0; lsu_wr = 1'b0; lsu_size = 3'd0; lsu_addr = '0; lsu_wdata = '0;
    misbranch_flag = 1'b0; io_buffer_full = 1'b0;
    ram[32'h0] = 8'h13; ram[32'h1] = 8'h00; ram[32'h2] = 8'h00; ram[32'h3] = 8'h00;
    ram[32'h100] = 8'hAA; ram[32'h101] = 8'hBB; ram[32'h102] = 8'hCC; ram[32'h103] = 8'hDD;
    ram[32'h200] = 8'h93; ram[32'h201] = 8'h01; ram[32'h202] = 8'h10; ram[32'h203] = 8'h00;

    // reset with fetch already requested
    repeat (3) tick();
    chk("rst_flags", {21'd0, if_done, lsu_done, mem_wr, mem_dout}, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_lsu_rdata", lsu_rdata, 32'h0);
    rst = 1'b1;
    tick();
    chk("fetch_a0", mem_a, 32'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("fetch_a", mem_a, 32'(i));
    end
    tick();
    chk("fetch_not_early", if_done, 1'b0);
    tick();
    chk("fetch_done", if_done, 1'b1);
    chk("fetch_rdata", if_rdata, 32'h00000013);
    if_en = 1'b0;
    tick();
    chk("fetch_done_1cyc", if_done, 1'b0);

    // LW and LB
    pulse_lsu(1'b0, 3'd4, 32'h100, 32'h0);
    wait_lsu_done(lat);
    chk("lw_lat", lat, 5);
    chk("lw_rdata", lsu_rdata, 32'hDDCCBBAA);
    tick();
    pulse_lsu(1'b0, 3'd1, 32'h101, 32'h0);
    wait_lsu_done(lat);
    chk("lb_lat", lat, 2);
    chk("lb_rdata", lsu_rdata, 32'h000000BB);
    chk("lb_if_rdata_kept", if_rdata, 32'h00000013);
    tick();

    // SH to IO space with the buffer full for three cycles
    wlog_a.delete(); wlog_d.delete();
    io_buffer_full = 1'b1;
    pulse_lsu(1'b1, 3'd2, 32'h30000, 32'h1234);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      if (mem_wr === 1'b0 && mem_a === 32'h30000) cnt++;
    end
    chk("sh_stall_cycles", cnt, 3);
    io_buffer_full = 1'b0;
    #1;
    chk("sh_b0_wr", mem_wr, 1'b1);
    chk("sh_b0_dout", mem_dout, 8'h34);
    tick();
    chk("sh_b1_a", mem_a, 32'h30001);
    chk("sh_b1_dout", mem_dout, 8'h12);
    tick();
    chk("sh_done", lsu_done, 1'b1);
    chk("sh_wr_off", mem_wr, 1'b0);
    chk("sh_nwrites", wlog_a.size(), 2);
    chk("sh_w0_a", wlog_a[0], 32'h30000);
    chk("sh_w0_d", wlog_d[0], 8'h34);
    chk("sh_w1_a", wlog_a[1], 32'h30001);
    chk("sh_w1_d", wlog_d[1], 8'h12);
    tick();

    // round-robin
    if_en = 1'b1; if_addr = 32'h200;
    tick();
    chk("rr_if_first", mem_a, 32'h200);
    pulse_lsu(1'b0, 3'd4, 32'h100, 32'h0);
    wait_if_done(lat);
    chk("rr_if_lat", lat, 4);
    chk("rr_if_rdata", if_rdata, 32'h00100193);
    tick();
    chk("rr_lsu_next", mem_a, 32'h100);
    pulse_lsu(1'b0, 3'd1, 32'h103, 32'h0);
    wait_lsu_done(lat);
    chk("rr_lsu_lat", lat, 4);
    chk("rr_lsu_rdata", lsu_rdata, 32'hDDCCBBAA);
    tick();
    chk("rr_if_after_lsu", mem_a, 32'h200);
    wait_if_done(lat);
    chk("rr_if2_lat", lat, 5);
    tick();
    chk("rr_lsu_pending", mem_a, 32'h103);
    wait_lsu_done(lat);
    chk("rr_lsu2_lat", lat, 2);
    chk("rr_lsu2_rdata", lsu_rdata, 32'h000000DD);
    exp_lsu = 1'b0; prev_lsu = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (prev_lsu) begin
        lsu_en = 1'b1; lsu_wr = 1'b0; lsu_size = 3'd1; lsu_addr = 32'h100;
      end
      tick();
      lsu_en = 1'b0;
      lat = 0;
      while (!(if_done === 1'b1 || lsu_done === 1'b1) && lat < 30) begin tick(); lat++; end
      chk("rr_alternate", {30'd0, if_done, lsu_done}, exp_lsu ? 32'd1 : 32'd2);
      prev_lsu = (lsu_done === 1'b1);
      exp_lsu = ~exp_lsu;
    end
    if_en = 1'b0;
    tick();

    // flush during byte 2 of a fetch with an LSU read queued
    if_en = 1'b1; if_addr = 32'h200;
    tick();
    pulse_lsu(1'b0, 3'd4, 32'h100, 32'h0);
    tick();
    chk("mb_byte2_a", mem_a, 32'h202);
    misbranch_flag = 1'b1; if_en = 1'b0;
    tick();
    misbranch_flag = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (if_done === 1'b1 || lsu_done === 1'b1) cnt++;
      tick();
    end
    chk("mb_no_done", cnt, 0);
    chk("mb_a_hold", mem_a, 32'h202);

    // flush during a fetch with an LSU write queued: the write still runs
    if_en = 1'b1; if_addr = 32'h200;
    tick();
    wlog_a.delete(); wlog_d.delete();
    pulse_lsu(1'b1, 3'd2, 32'h600, 32'hBEEF);
    tick();
    misbranch_flag = 1'b1; if_en = 1'b0;
    tick();
    misbranch_flag = 1'b0;
    wait_lsu_done(lat);
    chk("mbw_lat", lat, 3);
    chk("mbw_nwrites", wlog_a.size(), 2);
    chk("mbw_w0", {wlog_a[0][23:0], wlog_d[0]}, 32'h00060_0EF);
    chk("mbw_w1", {wlog_a[1][23:0], wlog_d[1]}, 32'h00060_1BE);
    tick();

    // read pulse on the same edge as a flush is dropped
    lsu_en = 1'b1; lsu_wr = 1'b0; lsu_size = 3'd4; lsu_addr = 32'h100;
    misbranch_flag = 1'b1;
    tick();
    lsu_en = 1'b0; misbranch_flag = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (lsu_done === 1'b1) cnt++;
      tick();
    end
    chk("mb_same_edge_drop", cnt, 0);

    // SW is not aborted by a flush
    wlog_a.delete(); wlog_d.delete();
    pulse_lsu(1'b1, 3'd4, 32'h400, 32'hCAFEF00D);
    tick();
    misbranch_flag = 1'b1;
    tick();
    misbranch_flag = 1'b0;
    wait_lsu_done(lat);
    chk("sw_mb_lat", lat + 2, 4);
    chk("sw_nwrites", wlog_a.size(), 4);
    sw_word = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      chk("sw_w_a", wlog_a[i], 32'h400 + 32'(i));
      chk("sw_w_d", wlog_d[i], sw_word[8*i +: 8]);
    end
    tick();

    // rdy low for 4 cycles mid-read
    pulse_lsu(1'b0, 3'd4, 32'h100, 32'h0);
    tick();
    rdy = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_a === 32'h101 && mem_wr === 1'b0 && lsu_done === 1'b0) cnt++;
    end
    chk("rdy_frozen", cnt, 4);
    rdy = 1'b1;
    wait_lsu_done(lat);
    chk("rdy_lat", 5 + lat, 9);
    chk("rdy_rdata", lsu_rdata, 32'hDDCCBBAA);
    tick();

    // rdy low during a write gates the strobe
    wlog_a.delete(); wlog_d.delete();
    pulse_lsu(1'b1, 3'd1, 32'h500, 32'h77);
    chk("rdyw_wr_on", mem_wr, 1'b1);
    rdy = 1'b0;
    #1;
    chk("rdyw_wr_off", mem_wr, 1'b0);
    tick();
    tick();
    chk("rdyw_hold", {30'd0, mem_wr, lsu_done}, 32'd0);
    rdy = 1'b1;
    #1;
    chk("rdyw_wr_resume", mem_wr, 1'b1);
    tick();
    chk("rdyw_done", lsu_done, 1'b1);
    chk("rdyw_nwrites", wlog_a.size(), 1);
    chk("rdyw_w0", {wlog_a[0][23:0], wlog_d[0]}, 32'h00050_077);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single byte-wide RAM/IO port. It serves two requesters: instruction fetch (32-bit word reads) and the load/store unit (1/2/4-byte reads and writes). It arbitrates between them and splits each access into byte cycles on the RAM bus. It returns assembled little-endian data with a one-cycle done pulse, and it drops speculative reads on a branch misprediction.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global enable; low freezes every register.
- `if_en`  in  1  fetch request; level, held until `if_done`.
- `if_addr`  in  32  fetch byte address.
- `if_done`  out  1  one-cycle pulse; `if_rdata` valid.
- `if_rdata`  out  32  fetched word, little-endian.
- `lsu_en`  in  1  LSU request; single-cycle pulse.
- `lsu_wr`  in  1  1 = write, 0 = read.
- `lsu_size`  in  3  byte count: 1, 2 or 4.
- `lsu_addr`  in  32  LSU byte address.
- `lsu_wdata`  in  32  write data; low `lsu_size` bytes are used.
- `lsu_done`  out  1  one-cycle pulse: read data valid, or write complete.
- `lsu_rdata`  out  32  read data, zero-extended above `lsu_size` bytes.
- `misbranch_flag`  in  1  flush of speculative reads.
- `mem_din`  in  8  RAM read byte, valid the cycle after its address is sampled.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  32  RAM byte address.
- `mem_wr`  out  1  write strobe, gated with `rdy`.
- `io_buffer_full`  in  1  IO write stall for addresses with `addr[17:16]==2'b11`.

## Operation
- **Reset** (`rst` low, asynchronous): state IDLE, pending LSU slot empty, last-grant = IF. All outputs are 0.
- **Request capture**
  - An `lsu_en` pulse latches op, size, address and wdata into a one-entry pending slot.
  - A second pulse while the slot is full or busy is illegal; the LSU guarantees this cannot happen.
  - `if_en` is sampled live and is not latched.
- **Arbitration** (only in IDLE):
  - If only one requester is pending, it is granted.
  - If both are pending, the grant goes to the one not granted last (round-robin).
  - The grant loads addr, byte count N (IF: 4) and byte index k=0.
  - The next state is READ or WRITE.
- **READ**
  - Cycle k drives `mem_a` = addr+k for k = 0..N-1.
  - Byte k is captured from `mem_din` one cycle later into bits [8k+7:8k].
  - After byte N-1 is captured, pulse done for the granted port and return to IDLE.
- **WRITE**
  - Cycle k drives `mem_a` = addr+k, `mem_dout` = wdata[8k+7:8k] and `mem_wr` = 1.
  - When `io_buffer_full` = 1 and `addr[17:16]==2'b11`, drive `mem_wr` = 0, do not advance k, and retry the same byte next cycle.
  - After byte N-1 is written, pulse `lsu_done` and return to IDLE.
- **misbranch_flag** (sampled at the edge):
  - In READ: abort, go to IDLE, no done pulse; the partial data is discarded.
  - The pending slot is cleared if it holds a read; a pending write is kept.
  - A same-edge `lsu_en` read pulse is dropped.
  - WRITE is never aborted, and a pending write is never dropped.
- **Outside transactions**: `mem_wr` = 0 whenever not in WRITE. `mem_a` and `mem_dout` hold their last value in IDLE.
- **rdy low**: all state, counters and outputs hold. `mem_wr` is forced to 0 while `rdy` is low.

## Timing
- Grant at edge t, in IDLE.
- **Read of N bytes**:
  - `mem_a` = addr+k during cycle t+k.
  - Byte k is captured at edge t+k+2.
  - Done is high during cycle t+N+1, and exactly one cycle.
  - IF word: done 5 cycles after grant.
- **Write of N bytes** (no IO stall):
  - Byte k is on the bus during cycle t+k.
  - `lsu_done` is high during cycle t+N.
- The state is IDLE in the done cycle; the next grant happens no earlier than the done edge. This gives a one-cycle bubble between transactions.
- An `lsu_en` pulse arriving in IDLE with no competing IF is granted at the same edge it is latched; there is no extra cycle.
- Done pulses for IF and LSU never coincide.
- `*_rdata` stays stable from the done cycle until the next done for that port.

## Test plan
- **Reset**: hold `rst` = 0 for 3 cycles with `if_en` = 1 → all outputs 0. Release → IF granted, `mem_a` 0x0..0x3. RAM bytes 13,00,00,00 → `if_rdata` = 0x00000013 with `if_done` 5 cycles after grant.
- **LW**: LSU read, size 4, addr 0x100, RAM bytes AA,BB,CC,DD → `lsu_rdata` = 0xDDCCBBAA. LB from 0x101 → 0x000000BB.
- **SH with IO stall**: write size 2, addr 0x30000, wdata 0x1234, `io_buffer_full` high 3 cycles → `mem_wr` low 3 cycles, then 0x34 @0x30000 and 0x12 @0x30001. `lsu_done` after the second byte.
- **Round-robin**: `if_en` held, LSU pulse during an IF read → LSU granted next. With both pending after that → IF granted. No starvation over 10 alternating requests.
- **misbranch**:
  - During byte 2 of an IF read → no `if_done`, state returns to IDLE.
  - During an SW write → all 4 bytes are still written and `lsu_done` pulses.
  - With a read pending → the pending read is discarded.
- **rdy**: `rdy` low for 4 cycles mid-read → `mem_a` frozen and `mem_wr` = 0. Done arrives 4 cycles later than nominal with correct data.
